// File: rtl/poseidon_frame_collector.sv
// Collects ELEMS field-element beats into one Poseidon state vector and holds
// it until the permutation core takes it; framing errors are flagged and counted.
module poseidon_frame_collector #(
  parameter int WIDTH = 255,
  parameter int ELEMS = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [WIDTH-1:0]       in_payload,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*ELEMS-1:0] out_state,
  output logic [6:0]             out_id,
  output logic                   err_pulse,
  output logic [7:0]             err_count
);

  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int BUF_N = (ELEMS > 1) ? ELEMS - 1 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

  typedef enum logic [1:0] {COLLECT, HOLD, DISCARD} state_t;

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [WIDTH-1:0]         elem_p0 [BUF_N];
  logic [WIDTH*ELEMS-1:0]   frame_vec;
  logic                     accept;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign accept = in_valid && in_ready;

  // Stage p0: staging buffer for all but the final element of a frame.
  always_ff @(posedge clk) begin
    if (state == COLLECT && accept && idx != LAST_IDX && !in_last) begin
      for (int k = 0; k < BUF_N; k++) begin
        if (idx == IDX_W'(k)) elem_p0[k] <= in_payload;
      end
    end
  end

  // The final element bypasses the buffer so the whole vector lands in one edge.
  always_comb begin
    frame_vec = '0;
    for (int k = 0; k < ELEMS - 1; k++) begin
      frame_vec[k*WIDTH +: WIDTH] = elem_p0[k];
    end
    frame_vec[(ELEMS-1)*WIDTH +: WIDTH] = in_payload;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= COLLECT;
      idx       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_state <= '0;
      out_id    <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        COLLECT: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (in_last) begin
                state     <= HOLD;
                out_state <= frame_vec;
                out_valid <= 1'b1;
                in_ready  <= 1'b0;
              end else begin
                state     <= DISCARD;
                err_pulse <= 1'b1;
                err_count <= sat_inc(err_count);
              end
            end else if (in_last) begin
              idx       <= '0;
              err_pulse <= 1'b1;
              err_count <= sat_inc(err_count);
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            out_id    <= out_id + 7'd1;
            in_ready  <= 1'b1;
          end
        end
        DISCARD: begin
          in_ready <= 1'b1;
          if (accept && in_last) begin
            state <= COLLECT;
            idx   <= '0;
          end
        end
        default: begin
          state     <= COLLECT;
          idx       <= '0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poseidon_frame_collector.sv
// Directed and randomized bench for poseidon_frame_collector with a frame-level
// reference model (frame length decides output vs. framing error).
module tb_poseidon_frame_collector;

  localparam int WIDTH = 255;
  localparam int ELEMS = 3;
  localparam int SW    = WIDTH * ELEMS;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_last = 1'b0;
  logic [WIDTH-1:0] in_payload = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [SW-1:0]    out_state;
  logic [6:0]       out_id;
  logic             err_pulse;
  logic [7:0]       err_count;

  poseidon_frame_collector #(.WIDTH(WIDTH), .ELEMS(ELEMS)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .out_id(out_id),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // reference model
  logic [SW-1:0] exp_state[$];
  int            exp_id[$];
  int            next_id = 0;
  int            exp_err = 0;

  // observations
  logic [SW-1:0] obs_state[$];
  int            obs_id[$];
  int            hs_cyc[$];
  int            rise_cyc[$];
  int            err_seen = 0;
  int            unstable = 0;
  int            ready_mode = 0;
  int            last_acc_cyc = 0;

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_elem();
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = (v << 32) | WIDTH'($urandom);
    return v;
  endfunction

  // Output monitor: drives out_ready and records every handshake.
  initial begin : monitor
    logic          held;
    logic [SW-1:0] h_state;
    logic [6:0]    h_id;
    held = 1'b0;
    h_state = '0;
    h_id = '0;
    forever begin
      @(negedge clk);
      if (err_pulse) err_seen++;
      if (!resetn) begin
        held = 1'b0;
        out_ready = 1'b0;
      end else begin
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = ($urandom_range(0, 2) != 0);
          default: out_ready = 1'b0;
        endcase
        if (out_valid) begin
          if (in_ready) unstable++;
          if (held) begin
            if (out_state !== h_state || out_id !== h_id) unstable++;
          end else begin
            rise_cyc.push_back(cyc);
          end
          if (out_ready) begin
            obs_state.push_back(out_state);
            obs_id.push_back(int'(out_id));
            hs_cyc.push_back(cyc);
            held = 1'b0;
          end else begin
            held = 1'b1;
            h_state = out_state;
            h_id = out_id;
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    obs_state.delete();
    obs_id.delete();
    hs_cyc.delete();
    rise_cyc.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    chki("rst_in_ready", int'(in_ready), 0);
    chki("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_state", out_state, '0);
    chki("rst_out_id", int'(out_id), 0);
    chki("rst_err_pulse", int'(err_pulse), 0);
    chki("rst_err_count", int'(err_count), 0);
    exp_state.delete();
    exp_id.delete();
    clear_obs();
    next_id = 0;
    exp_err = 0;
    err_seen = 0;
    resetn = 1'b1;
    @(negedge clk);
    chki("in_ready_after_reset", int'(in_ready), 1);
  endtask

  // Drives one frame of len beats; fixed=1 uses payloads 1,2,3,...
  task automatic send_frame(input int len, input bit gaps, input bit fixed);
    logic [WIDTH-1:0] p [ELEMS];
    logic [WIDTH-1:0] pl;
    logic [SW-1:0]    f;
    int               n;
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_last = 1'b0;
        end
      end
      @(negedge clk);
      pl = fixed ? WIDTH'(i + 1) : rand_elem();
      in_valid = 1'b1;
      in_last = (i == len - 1);
      in_payload = pl;
      n = 0;
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) chki("beat_accept_timeout", n, 0);
      last_acc_cyc = cyc + 1;
      if (i < ELEMS) p[i] = pl;
    end
    if (len == ELEMS) begin
      f = '0;
      for (int k = 0; k < ELEMS; k++) f[k*WIDTH +: WIDTH] = p[k];
      exp_state.push_back(f);
      exp_id.push_back(next_id);
      next_id = (next_id + 1) % 128;
    end else begin
      exp_err++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    idle();
    n = 0;
    while ((obs_state.size() < exp_state.size() || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chki("drain_timeout", n, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_frames(input string tag);
    int m;
    chki($sformatf("%s_frame_count", tag), obs_state.size(), exp_state.size());
    m = (obs_state.size() < exp_state.size()) ? obs_state.size() : exp_state.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_state[%0d]", tag, i), obs_state[i], exp_state[i]);
      chki($sformatf("%s_id[%0d]", tag, i), obs_id[i], exp_id[i]);
    end
    exp_state.delete();
    exp_id.delete();
    clear_obs();
  endtask

  task automatic chk_errs(input string tag);
    chki($sformatf("%s_err_pulses", tag), err_seen, exp_err);
    chki($sformatf("%s_err_count", tag), int'(err_count), (exp_err > 255) ? 255 : exp_err);
  endtask

  initial begin : stimulus
    logic [SW-1:0] c1;
    logic [SW-1:0] cap;
    int            n;
    int            len;

    apply_reset();

    // basic frame 1,2,3
    ready_mode = 0;
    send_frame(3, 1'b0, 1'b1);
    drain();
    chki("t1_latency", (rise_cyc.size() > 0) ? rise_cyc[0] : -1, last_acc_cyc);
    c1 = '0;
    c1[0*WIDTH +: WIDTH] = WIDTH'(1);
    c1[1*WIDTH +: WIDTH] = WIDTH'(2);
    c1[2*WIDTH +: WIDTH] = WIDTH'(3);
    chk("t1_state_const", (obs_state.size() > 0) ? obs_state[0] : 'x, c1);
    chki("t1_id_const", (obs_id.size() > 0) ? obs_id[0] : -1, 0);
    compare_frames("t1");
    chk_errs("t1");

    // short frame then valid frame
    apply_reset();
    send_frame(2, 1'b0, 1'b0);
    send_frame(3, 1'b0, 1'b0);
    drain();
    chki("t3_id_const", (obs_id.size() > 0) ? obs_id[0] : -1, 0);
    chki("t3_err_pulses_const", err_seen, 1);
    chki("t3_err_count_const", int'(err_count), 1);
    compare_frames("t3");

    // long frame then valid frame
    send_frame(5, 1'b0, 1'b0);
    send_frame(3, 1'b0, 1'b0);
    drain();
    compare_frames("t4");
    chk_errs("t4");

    // backpressure in HOLD
    ready_mode = 2;
    send_frame(3, 1'b0, 1'b0);
    idle();
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chki("t5_valid_seen", int'(out_valid), 1);
    cap = out_state;
    repeat (10) begin
      @(negedge clk);
      chki("t5_in_ready_low", int'(in_ready), 0);
      chki("t5_valid_held", int'(out_valid), 1);
      chk("t5_state_stable", out_state, cap);
    end
    ready_mode = 0;
    drain();
    compare_frames("t5");

    // 100 back-to-back frames
    apply_reset();
    for (int i = 0; i < 100; i++) send_frame(3, 1'b0, 1'b0);
    drain();
    chki("t2_handshakes", hs_cyc.size(), 100);
    for (int i = 1; i < hs_cyc.size(); i++)
      chki($sformatf("t2_spacing[%0d]", i), hs_cyc[i] - hs_cyc[i-1], 4);
    compare_frames("t2");
    chki("t2_err_count", int'(err_count), 0);

    // randomized lengths, gaps and backpressure
    ready_mode = 1;
    for (int i = 0; i < 200; i++) begin
      len = ($urandom_range(0, 9) < 6) ? 3 : $urandom_range(1, 6);
      send_frame(len, 1'b1, 1'b0);
    end
    drain();
    ready_mode = 0;
    compare_frames("t6");
    chk_errs("t6");

    // out_id wrap, then reset mid-frame
    apply_reset();
    for (int i = 0; i < 130; i++) send_frame(3, 1'b0, 1'b0);
    drain();
    chki("t7_id127", (obs_id.size() > 127) ? obs_id[127] : -1, 127);
    chki("t7_id128", (obs_id.size() > 128) ? obs_id[128] : -1, 0);
    chki("t7_id129", (obs_id.size() > 129) ? obs_id[129] : -1, 1);
    compare_frames("t7");
    @(negedge clk);
    in_valid = 1'b1;
    in_last = 1'b0;
    in_payload = rand_elem();
    @(negedge clk);
    in_payload = rand_elem();
    resetn = 1'b0;
    @(negedge clk);
    chki("t7_rst_in_ready", int'(in_ready), 0);
    chki("t7_rst_out_valid", int'(out_valid), 0);
    chk("t7_rst_out_state", out_state, '0);
    chki("t7_rst_out_id", int'(out_id), 0);
    chki("t7_rst_err_count", int'(err_count), 0);
    in_valid = 1'b0;
    resetn = 1'b1;
    next_id = 0;
    exp_err = 0;
    err_seen = 0;
    repeat (12) @(negedge clk);
    chki("t7_no_emit", obs_state.size(), 0);
    chki("t7_out_valid_idle", int'(out_valid), 0);
    chki("t7_no_err_pulse", err_seen, 0);
    chki("t7_in_ready_up", int'(in_ready), 1);
    send_frame(3, 1'b0, 1'b0);
    drain();
    compare_frames("t7b");

    // err_count saturation
    apply_reset();
    for (int i = 0; i < 260; i++) send_frame(1, 1'b0, 1'b0);
    drain();
    chk_errs("t8");

    chki("protocol_stability", unstable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
